// File: rtl/sb_pkg.sv
// Shared types and helpers for the issue scoreboard: width derivation, lane
// request record and producer-latency saturation.
package sb_pkg;

  // Upper bounds for the lane request fields; lanes zero-extend into these.
  localparam int RW_MAX = 8;
  localparam int LW_MAX = 8;

  function automatic int sb_rw(input int nregs);
    return $clog2(nregs);
  endfunction

  function automatic int sb_lw(input int max_lat);
    return $clog2(max_lat + 1);
  endfunction

  typedef struct packed {
    logic              valid;
    logic [RW_MAX-1:0] rs;
    logic [RW_MAX-1:0] rt;
    logic [RW_MAX-1:0] rd;
    logic              rsuse;
    logic              rtuse;
    logic              wen;
    logic [LW_MAX-1:0] lat;
  } lane_req_t;

  function automatic logic [LW_MAX-1:0] sat_lat(input logic [LW_MAX-1:0] lat,
                                                input int max_lat);
    if (int'(lat) > max_lat) return LW_MAX'(max_lat);
    return lat;
  endfunction

endpackage

// File: rtl/sb_reg_entry.sv
// One scoreboard slot: pending-latency counter plus the "issued last cycle"
// marker that lets a flush cancel only the killed producer.
module sb_reg_entry #(
  parameter int LW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          hold,
  input  logic          wr,
  input  logic [LW-1:0] wr_lat,
  output logic [LW-1:0] cnt
);

  logic          young;
  logic [LW-1:0] cnt_dec;

  assign cnt_dec = (cnt != '0) ? cnt - LW'(1) : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt   <= '0;
      young <= 1'b0;
    end else if (flush) begin
      cnt   <= young ? '0 : cnt_dec;
      young <= 1'b0;
    end else if (!hold) begin
      if (wr) begin
        cnt   <= wr_lat;
        young <= 1'b1;
      end else begin
        cnt   <= cnt_dec;
        young <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/pipe_scoreboard.sv
// N-wide in-order issue scoreboard with per-register pending-latency counters.
// Define SB_BYPASS_EN when a forwarding path covers the completing stage.
module pipe_scoreboard
  import sb_pkg::*;
#(
  parameter  int LANES   = 2,
  parameter  int NREGS   = 32,
  parameter  int MAX_LAT = 7,
  localparam int RW      = sb_rw(NREGS),
  localparam int LW      = sb_lw(MAX_LAT)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [LANES-1:0]    iss_valid,
  input  logic [LANES*RW-1:0] iss_rs,
  input  logic [LANES*RW-1:0] iss_rt,
  input  logic [LANES-1:0]    iss_rsuse,
  input  logic [LANES-1:0]    iss_rtuse,
  input  logic [LANES*RW-1:0] iss_rd,
  input  logic [LANES-1:0]    iss_wen,
  input  logic [LANES*LW-1:0] iss_lat,
  input  logic                hold,
  input  logic                flush,
  output logic [LANES-1:0]    issue_ok,
  output logic [NREGS-1:0]    busy
);

  lane_req_t         req     [LANES];
  logic [LW_MAX-1:0] lat_sat [LANES];
  logic [LW-1:0]     cnt     [NREGS];
  logic [LANES-1:0]  raw_ok;
  logic              chain;
  logic [NREGS-1:1]  wr_vec;
  logic [LW-1:0]     wr_lat  [1:NREGS-1];

  // With forwarding, a producer in its final cycle is already usable.
  function automatic logic src_ready(input logic [LW-1:0] c);
`ifdef SB_BYPASS_EN
    return (c <= LW'(1));
`else
    return (c == '0);
`endif
  endfunction

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      req[i].valid = iss_valid[i];
      req[i].rs    = RW_MAX'(iss_rs[i*RW +: RW]);
      req[i].rt    = RW_MAX'(iss_rt[i*RW +: RW]);
      req[i].rd    = RW_MAX'(iss_rd[i*RW +: RW]);
      req[i].rsuse = iss_rsuse[i];
      req[i].rtuse = iss_rtuse[i];
      req[i].wen   = iss_wen[i];
      req[i].lat   = LW_MAX'(iss_lat[i*LW +: LW]);
      lat_sat[i]   = sat_lat(req[i].lat, MAX_LAT);
    end
  end

  always_comb begin
    raw_ok = '0;
    for (int j = 0; j < LANES; j++) begin
      raw_ok[j] = 1'b1;
      if (req[j].rsuse && !src_ready(cnt[req[j].rs[RW-1:0]])) raw_ok[j] = 1'b0;
      if (req[j].rtuse && !src_ready(cnt[req[j].rt[RW-1:0]])) raw_ok[j] = 1'b0;
      if (req[j].wen && (LW_MAX'(cnt[req[j].rd[RW-1:0]]) > lat_sat[j])) raw_ok[j] = 1'b0;
      // Older writers in the same bundle are not yet in the counters.
      for (int i = 0; i < j; i++) begin
        if (req[i].valid && req[i].wen && (req[i].rd != '0) &&
            ((req[j].rsuse && (req[i].rd == req[j].rs)) ||
             (req[j].rtuse && (req[i].rd == req[j].rt)) ||
             (req[j].wen   && (req[i].rd == req[j].rd))))
          raw_ok[j] = 1'b0;
      end
    end
  end

  always_comb begin
    issue_ok = '0;
    chain    = ~(hold | flush);
    for (int i = 0; i < LANES; i++) begin
      issue_ok[i] = chain & req[i].valid & raw_ok[i];
      chain       = issue_ok[i];
    end
  end

  // Issue latency of zero still occupies the register for one cycle.
  always_comb begin
    for (int r = 1; r < NREGS; r++) begin
      wr_vec[r] = 1'b0;
      wr_lat[r] = LW'(1);
      for (int i = 0; i < LANES; i++) begin
        if (issue_ok[i] && req[i].wen && (req[i].rd == RW_MAX'(r))) begin
          wr_vec[r] = 1'b1;
          wr_lat[r] = (lat_sat[i] == '0) ? LW'(1) : lat_sat[i][LW-1:0];
        end
      end
    end
  end

  assign cnt[0] = '0;

  for (genvar r = 1; r < NREGS; r++) begin : g_ent
    sb_reg_entry #(.LW(LW)) u_ent (
      .clk    (clk),
      .reset  (reset),
      .flush  (flush),
      .hold   (hold),
      .wr     (wr_vec[r]),
      .wr_lat (wr_lat[r]),
      .cnt    (cnt[r])
    );
  end

  always_comb begin
    for (int r = 0; r < NREGS; r++) busy[r] = (cnt[r] != '0);
  end

endmodule

// File: tb/tb_pipe_scoreboard.sv
// Directed scoreboard bench for pipe_scoreboard; expectations track SB_BYPASS_EN.
module tb_pipe_scoreboard;

  localparam int LANES = 2;
  localparam int NREGS = 32;
  localparam int RW    = 5;
  localparam int LW    = 3;
`ifdef SB_BYPASS_EN
  localparam bit BP = 1'b1;
`else
  localparam bit BP = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                reset;
  logic [LANES-1:0]    iss_valid, iss_rsuse, iss_rtuse, iss_wen;
  logic [LANES*RW-1:0] iss_rs, iss_rt, iss_rd;
  logic [LANES*LW-1:0] iss_lat;
  logic                hold, flush;
  logic [LANES-1:0]    issue_ok;
  logic [NREGS-1:0]    busy;

  pipe_scoreboard #(.LANES(LANES), .NREGS(NREGS), .MAX_LAT(7)) dut (
    .clk(clk), .reset(reset), .iss_valid(iss_valid), .iss_rs(iss_rs),
    .iss_rt(iss_rt), .iss_rsuse(iss_rsuse), .iss_rtuse(iss_rtuse),
    .iss_rd(iss_rd), .iss_wen(iss_wen), .iss_lat(iss_lat), .hold(hold),
    .flush(flush), .issue_ok(issue_ok), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [1:0]  ok;
    logic [31:0] m;
    logic [31:0] b;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic logic [31:0] bm(input int r);
    return 32'd1 << r;
  endfunction

  task automatic idle();
    iss_valid = '0; iss_rsuse = '0; iss_rtuse = '0; iss_wen = '0;
    iss_rs = '0; iss_rt = '0; iss_rd = '0; iss_lat = '0;
    hold = 1'b0; flush = 1'b0;
  endtask

  task automatic tick();
    @(negedge clk);
    idle();
  endtask

  task automatic lane(input int i, input int rs, input bit ru, input int rt,
                      input bit tu, input int rd, input bit w, input int lat);
    logic [4:0] rs5, rt5, rd5;
    logic [2:0] l3;
    rs5 = rs[4:0]; rt5 = rt[4:0]; rd5 = rd[4:0]; l3 = lat[2:0];
    iss_valid[i] = 1'b1;
    iss_rs[i*RW +: RW] = rs5;  iss_rsuse[i] = ru;
    iss_rt[i*RW +: RW] = rt5;  iss_rtuse[i] = tu;
    iss_rd[i*RW +: RW] = rd5;  iss_wen[i]   = w;
    iss_lat[i*LW +: LW] = l3;
  endtask

  task automatic wr(input int i, input int rd, input int lat);
    lane(i, 0, 1'b0, 0, 1'b0, rd, 1'b1, lat);
  endtask

  task automatic use_rs(input int i, input int rs, input int rd);
    lane(i, rs, 1'b1, 0, 1'b0, rd, 1'b1, 1);
  endtask

  task automatic chk(input string nm, input logic [1:0] ok,
                     input logic [31:0] m, input logic [31:0] b);
    exp_t e;
    e.nm = nm; e.ok = ok; e.m = m; e.b = b;
    q.push_back(e);
  endtask

  // Monitor: outputs for the vector driven at a negedge are sampled 2 units later.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        n_chk++;
        if (issue_ok !== e.ok) begin
          n_fail++;
          $display("FAIL %s issue_ok: got %b expected %b", e.nm, issue_ok, e.ok);
        end
        n_chk++;
        if ((busy & e.m) !== (e.b & e.m)) begin
          n_fail++;
          $display("FAIL %s busy: got %h expected %h (mask %h)", e.nm,
                   busy & e.m, e.b & e.m, e.m);
        end
      end
    end
  end

  initial begin
    reset = 1'b0;
    idle();
    tick(); chk("reset", 2'b00, '1, '0);
    reset = 1'b1;

    tick(); wr(0, 3, 1); wr(1, 4, 1); chk("indep_issue", 2'b11, bm(3) | bm(4), '0);
    tick(); chk("lat1_busy", 2'b00, bm(3) | bm(4), bm(3) | bm(4));
    tick(); chk("lat1_clear", 2'b00, bm(3) | bm(4), '0);

    tick(); wr(0, 5, 4); chk("prod5", 2'b01, bm(5), '0);
    for (int k = 0; k < 3; k++) begin
      tick(); use_rs(0, 5, 6); chk("raw5_stall", 2'b00, bm(5), bm(5));
    end
    tick(); use_rs(0, 5, 6); chk("raw5_last", BP ? 2'b01 : 2'b00, bm(5), bm(5));
    tick(); if (!BP) use_rs(0, 5, 6); chk("raw5_go", BP ? 2'b00 : 2'b01, bm(5), '0);
    tick();

    tick(); wr(0, 7, 2); lane(1, 7, 1'b1, 0, 1'b0, 8, 1'b1, 1);
    chk("intra", 2'b01, bm(7), '0);
    tick(); use_rs(0, 7, 8); chk("intra_re_stall", 2'b00, bm(7), bm(7));
    tick(); use_rs(0, 7, 8); chk("intra_re_last", BP ? 2'b01 : 2'b00, bm(7), bm(7));
    tick(); if (!BP) use_rs(0, 7, 8); chk("intra_re_go", BP ? 2'b00 : 2'b01, bm(7), '0);
    tick();

    tick(); wr(0, 9, 3); chk("prod9", 2'b01, bm(9), '0);
    for (int k = 0; k < 2; k++) begin
      tick(); use_rs(0, 9, 13); wr(1, 14, 1);
      chk("inorder_block", 2'b00, bm(9) | bm(14), bm(9));
    end
    tick(); use_rs(0, 9, 13); wr(1, 14, 1);
    chk("inorder_last", BP ? 2'b11 : 2'b00, bm(9), bm(9));
    tick(); if (!BP) begin use_rs(0, 9, 13); wr(1, 14, 1); end
    chk("inorder_go", BP ? 2'b00 : 2'b11, bm(9), '0);
    tick(); tick();

    tick(); wr(0, 11, 6); chk("prod11", 2'b01, bm(11), '0);
    tick();
    tick(); wr(0, 10, 5); chk("prod10", 2'b01, bm(10) | bm(11), bm(11));
    tick(); flush = 1'b1; wr(0, 16, 1);
    chk("flush_forced", 2'b00, bm(10) | bm(11), bm(10) | bm(11));
    tick(); chk("flush_kill", 2'b00, bm(10) | bm(11) | bm(16), bm(11));
    tick();
    tick(); chk("old_count", 2'b00, bm(11), bm(11));
    tick(); chk("old_done", 2'b00, bm(11), '0);

    tick(); wr(0, 12, 3); chk("prod12", 2'b01, bm(12), '0);
    tick(); chk("cnt12", 2'b00, bm(12), bm(12));
    for (int k = 0; k < 3; k++) begin
      tick(); hold = 1'b1; wr(0, 17, 1);
      chk("hold", 2'b00, bm(12) | bm(17), bm(12));
    end
    tick(); chk("hold_rel", 2'b00, bm(12) | bm(17), bm(12));
    tick(); chk("hold_cnt1", 2'b00, bm(12), bm(12));
    tick(); chk("hold_done", 2'b00, bm(12), '0);

    tick(); wr(0, 0, 5); wr(1, 18, 1); chk("r0_write", 2'b11, bm(0), '0);
    tick(); lane(0, 0, 1'b1, 0, 1'b1, 19, 1'b1, 1);
    chk("r0_read", 2'b01, bm(0) | bm(18), bm(18));
    tick(); chk("r0_idle", 2'b00, bm(0), '0);

    tick(); wr(0, 20, 5); chk("prod20", 2'b01, bm(20), '0);
    tick(); wr(0, 20, 2); chk("waw_stall", 2'b00, bm(20), bm(20));
    tick(); wr(0, 20, 4); chk("waw_ok", 2'b01, bm(20), bm(20));
    tick(); wr(0, 21, 0); chk("lat0", 2'b01, bm(21), '0);
    tick(); chk("lat0_busy", 2'b00, bm(21), bm(21));
    tick(); chk("lat0_clear", 2'b00, bm(21) | bm(20), bm(20));

    tick(); #1 reset = 1'b0; chk("async_rst", 2'b00, '1, '0);
    tick(); reset = 1'b1; chk("post_rst", 2'b00, '1, '0);

    for (int k = 0; k < 5 && q.size() > 0; k++) @(negedge clk);
    #3;
    if (q.size() > 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
